seq_calculator: RTL and testbench
=================================

SEQ_CALCULATOR -- requirements
Module: seq_calculator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand width; legal range 2..32.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operand/opcode valid.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 data_a_in  input  WIDTH  operand A, unsigned.
REQ-007 data_b_in  input  WIDTH  operand B, unsigned.
REQ-008 function_in  input  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
REQ-009 out  output  2*WIDTH  registered result.
REQ-010 out_valid  output  1  out holds a result not yet taken.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 div_by_zero  output  1  qualifies out; set only for a div with B=0.

Function
REQ-013 An operation SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; operands and opcode SHALL be captured then, and later input changes SHALL NOT affect the result.
REQ-014 The FSM SHALL have states IDLE, CALC and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE.
REQ-016 IDLE, on accept: add, sub, or div with B=0 -> DONE; mul, or div with B!=0 -> CALC.
REQ-017 CALC SHALL run an iteration counter for exactly WIDTH cycles, then go to DONE.
REQ-018 DONE SHALL assert out_valid=1; out, out_valid and div_by_zero SHALL hold stable until out_ready=1, then go to IDLE with out_valid=0 on the next edge.
REQ-019 Latency from accept edge to out_valid=1: 1 cycle for add, sub and div-by-zero; WIDTH+1 cycles for mul and div.
REQ-020 Add: out = A + B, zero-extended to 2*WIDTH; carry lands in bit WIDTH.
REQ-021 Sub: out = (A - B) mod 2^(2*WIDTH), so a negative difference reads as its 2*WIDTH-bit two's complement.
REQ-022 Mul: shift-add, one partial-product bit per CALC cycle; out = A*B exactly, 2*WIDTH bits.
REQ-023 Div: restoring, one quotient bit per CALC cycle; out[WIDTH-1:0] = quotient, out[2*WIDTH-1:WIDTH] = remainder.
REQ-024 Div with B=0: quotient all ones, remainder = A, div_by_zero=1; div_by_zero SHALL be 0 for every other result.
REQ-025 in_valid while not in IDLE SHALL be ignored; no queuing.
REQ-026 out_ready while out_valid=0 SHALL have no effect.
REQ-027 No new operation SHALL be accepted on the same edge that a result is taken; the earliest next accept is the following edge.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, in_ready=1, out_valid=0, out=0, div_by_zero=0, iteration counter=0.
REQ-029 Reset during CALC or DONE SHALL abandon the operation with no result delivered.
REQ-030 The first accept after reset release SHALL be possible on the first rising edge with rst_n=1.

Verification (WIDTH=8)
REQ-031 add 200+100, out_ready=1 -> out=0x012C, out_valid high 1 cycle after accept, div_by_zero=0.
REQ-032 sub 3-5 -> out=0xFFFE after 1 cycle; then mul 255*255 -> out=0xFE01 exactly 9 cycles after accept.
REQ-033 div 100/7 -> out=0x020E (q=14, r=2) after 9 cycles; div 9/0 -> out=0x09FF, div_by_zero=1 after 1 cycle.
REQ-034 mul 12*10 with out_ready=0 for 5 cycles after out_valid -> out=0x0078 held stable, in_ready=0, new in_valid ignored; release -> in_ready=1 next cycle.
REQ-035 rst_n pulsed low in 4th CALC cycle of div 200/3 -> out_valid=0, out=0, in_ready=1 immediately; next op add 1+1 -> out=0x0002.

Source files
------------

// File: rtl/seq_calculator.sv
// seq_calculator: sequential add/sub/mul/div unit with valid/ready handshakes.
// Multiply (shift-add) and divide (restoring) take one bit per cycle in CALC.
`default_nettype none

module seq_calculator #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     data_a_in,
    input  logic [WIDTH-1:0]     data_b_in,
    input  logic [1:0]           function_in,
    output logic [2*WIDTH-1:0]   out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 is_div_q, is_div_d;
    logic [2*WIDTH-1:0]   work_q, work_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   out_q, out_d;
    logic                 dbz_q, dbz_d;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   step_next;

    // Multiply: work = {partial product, remaining multiplier bits}, shifted right each step.
    always_comb begin
        mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, work_q[WIDTH-1:1]};
    end

    // Divide: work = {partial remainder, dividend bits / quotient bits}, shifted left each step.
    always_comb begin
        div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, b_q}) : div_shift[WIDTH-1:0];
        div_next  = {div_rem, work_q[WIDTH-2:0], div_ge};
    end

    assign step_next = is_div_q ? div_next : mul_next;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        dbz_d    = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = data_a_in;
                    b_d      = data_b_in;
                    is_div_d = (function_in == OP_DIV);
                    cnt_d    = '0;
                    case (function_in)
                        OP_ADD: begin
                            out_d   = {{WIDTH{1'b0}}, data_a_in} + {{WIDTH{1'b0}}, data_b_in};
                            dbz_d   = 1'b0;
                            state_d = S_DONE;
                        end
                        OP_SUB: begin
                            out_d   = {{WIDTH{1'b0}}, data_a_in} - {{WIDTH{1'b0}}, data_b_in};
                            dbz_d   = 1'b0;
                            state_d = S_DONE;
                        end
                        OP_MUL: begin
                            work_d  = {{WIDTH{1'b0}}, data_b_in};
                            state_d = S_CALC;
                        end
                        default: begin
                            if (data_b_in == '0) begin
                                out_d   = {data_a_in, {WIDTH{1'b1}}};
                                dbz_d   = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                work_d  = {{WIDTH{1'b0}}, data_a_in};
                                state_d = S_CALC;
                            end
                        end
                    endcase
                end
            end
            S_CALC: begin
                work_d = step_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    out_d   = step_next;
                    dbz_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            work_q   <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            is_div_q <= is_div_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            dbz_q    <= dbz_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign out         = out_q;
    assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_calculator.sv
// Directed self-checking bench for seq_calculator at WIDTH=8.
`default_nettype none

module tb_seq_calculator;

    localparam int W = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    data_a_in = '0;
    logic [W-1:0]    data_b_in = '0;
    logic [1:0]      function_in = '0;
    logic [2*W-1:0]  out;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_calculator #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_a_in   (data_a_in),
        .data_b_in   (data_b_in),
        .function_in (function_in),
        .out         (out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .div_by_zero (div_by_zero)
    );

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  f;
        logic [15:0] exp;
        logic        dbz;
        logic [4:0]  lat;
    } vec_t;

    vec_t vecs [0:11];

    // Called at posedge+1; returns at accept-edge+1 with operands scrambled afterwards.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] f,
                         output bit ok);
        int k = 0;
        while (!in_ready && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        ok = in_ready;
        data_a_in = a; data_b_in = b; function_in = f; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_a_in = ~a; data_b_in = b + 8'd1; function_in = ~f;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        bit ok;
        int lat;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 16'h0 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b out=%h dbz=%b, expected rdy=1 vld=0 out=0000 dbz=0",
                     in_ready, out_valid, out, div_by_zero);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(8'd10, 8'd20, 2'b00, ok);
        wait_valid(lat);
        n_checks++;
        if (!ok || lat != 1 || out !== 16'h001E) begin
            n_fail++;
            $display("FAIL first_accept: got ok=%0d lat=%0d out=%h, expected ok=1 lat=1 out=001e",
                     ok, lat, out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        bit ok;
        int lat;
        vecs[0]  = '{8'd200, 8'd100, 2'b00, 16'h012C, 1'b0, 5'd1};
        vecs[1]  = '{8'd3,   8'd5,   2'b01, 16'hFFFE, 1'b0, 5'd1};
        vecs[2]  = '{8'd255, 8'd255, 2'b10, 16'hFE01, 1'b0, 5'd9};
        vecs[3]  = '{8'd100, 8'd7,   2'b11, 16'h020E, 1'b0, 5'd9};
        vecs[4]  = '{8'd9,   8'd0,   2'b11, 16'h09FF, 1'b1, 5'd1};
        vecs[5]  = '{8'd255, 8'd255, 2'b00, 16'h01FE, 1'b0, 5'd1};
        vecs[6]  = '{8'd0,   8'd255, 2'b01, 16'hFF01, 1'b0, 5'd1};
        vecs[7]  = '{8'd255, 8'd1,   2'b11, 16'h00FF, 1'b0, 5'd9};
        vecs[8]  = '{8'd5,   8'd9,   2'b11, 16'h0500, 1'b0, 5'd9};
        vecs[9]  = '{8'd0,   8'd77,  2'b10, 16'h0000, 1'b0, 5'd9};
        vecs[10] = '{8'd255, 8'd0,   2'b11, 16'hFFFF, 1'b1, 5'd1};
        vecs[11] = '{8'd7,   8'd13,  2'b10, 16'h005B, 1'b0, 5'd9};
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].f, ok);
            wait_valid(lat);
            n_checks++;
            if (!ok || lat != int'(vecs[i].lat)) begin
                n_fail++;
                $display("FAIL vec%0d_latency: got ok=%0d lat=%0d, expected ok=1 lat=%0d",
                         i, ok, lat, vecs[i].lat);
            end
            n_checks++;
            if (out !== vecs[i].exp || div_by_zero !== vecs[i].dbz) begin
                n_fail++;
                $display("FAIL vec%0d_result: got out=%h dbz=%b, expected out=%h dbz=%b",
                         i, out, div_by_zero, vecs[i].exp, vecs[i].dbz);
            end
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL vec%0d_drain: got vld=%b rdy=%b, expected vld=0 rdy=1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int lat;
        out_ready = 1'b1;
        issue(8'd1, 8'd2, 2'b00, ok);
        wait_valid(lat);
        data_a_in = 8'd4; data_b_in = 8'd5; function_in = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 16'h0003) begin
            n_fail++;
            $display("FAIL b2b_take_edge: got vld=%b rdy=%b out=%h, expected vld=0 rdy=1 out=0003",
                     out_valid, in_ready, out);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out !== 16'h0009) begin
            n_fail++;
            $display("FAIL b2b_next_accept: got vld=%b out=%h, expected vld=1 out=0009",
                     out_valid, out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        bit ok;
        int lat;
        out_ready = 1'b0;
        issue(8'd12, 8'd10, 2'b10, ok);
        wait_valid(lat);
        n_checks++;
        if (!ok || lat != 9) begin
            n_fail++;
            $display("FAIL stall_latency: got ok=%0d lat=%0d, expected ok=1 lat=9", ok, lat);
        end
        for (int c = 0; c < 5; c++) begin
            data_a_in = 8'd1; data_b_in = 8'd1; function_in = 2'b00; in_valid = 1'b1;
            @(posedge clk); #1;
            n_checks++;
            if (out !== 16'h0078 || out_valid !== 1'b1 || in_ready !== 1'b0 || div_by_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got out=%h vld=%b rdy=%b dbz=%b, expected out=0078 vld=1 rdy=0 dbz=0",
                         c, out, out_valid, in_ready, div_by_zero);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: got vld=%b rdy=%b, expected vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_calc();
        bit ok;
        int lat;
        out_ready = 1'b1;
        issue(8'd200, 8'd3, 2'b11, ok);
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midcalc_busy: got vld=%b rdy=%b, expected vld=0 rdy=0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out !== 16'h0 || in_ready !== 1'b1 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL midcalc_reset: got vld=%b out=%h rdy=%b dbz=%b, expected vld=0 out=0000 rdy=1 dbz=0",
                     out_valid, out, in_ready, div_by_zero);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(8'd1, 8'd1, 2'b00, ok);
        wait_valid(lat);
        n_checks++;
        if (!ok || lat != 1 || out !== 16'h0002) begin
            n_fail++;
            $display("FAIL post_reset_add: got ok=%0d lat=%0d out=%h, expected ok=1 lat=1 out=0002",
                     ok, lat, out);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_stall();
        test_reset_mid_calc();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
